// File: rtl/regfile_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_pkg
// Shared types and constants for the register-file dump controller.
//   dump_state_t : controller FSM state encoding
//   RF_DATA_W    : register / stream word width
//   RF_ADDR_W    : register address width
//   RF_DEPTH     : number of registers in the file
// The CSUM state is only reachable when REGFILE_DUMP_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package regfile_dump_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SEND_A = 3'd2,
    ST_SEND_B = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_csum.sv
// -----------------------------------------------------------------------------
// regfile_dump_csum
// XOR accumulator over the words emitted by a dump.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset, clears the sum
//   clr_i   in  clear the sum (takes priority over en_i)
//   en_i    in  XOR data_i into the sum
//   data_i  in  DATA_W word to accumulate
//   sum_o   out DATA_W running XOR
// Only instantiated when REGFILE_DUMP_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module regfile_dump_csum
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Read-side master for the register file. A start pulse walks a wrap-around
// address range, reading two registers per FETCH through the file's two
// combinational read ports, and streams them one word per valid/ready
// handshake.
// Ports:
//   clk, reset            clock / asynchronous active-low reset
//   start                 request, sampled in IDLE only
//   first_addr, last_addr inclusive wrap-around range, sampled with start
//   busy, done            status: busy while not IDLE, done one-cycle pulse
//   rf_read, rf_read1/2   register file read enable and port addresses
//   rf_value1/2           register file read data
//   out_data/valid/ready  output stream
//   out_last              marks the final word of the dump
// Configuration:
//   REGFILE_DUMP_CHECKSUM_EN  when defined, an XOR of all emitted words is
//                             appended as an extra final word (CSUM state).
// -----------------------------------------------------------------------------
module regfile_dump_ctrl
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              rf_read,
  output logic [ADDR_W-1:0] rf_read1,
  output logic [ADDR_W-1:0] rf_read2,
  input  logic [DATA_W-1:0] rf_value1,
  input  logic [DATA_W-1:0] rf_value2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  // One extra bit so a full range (2^ADDR_W words) is representable.
  localparam int CNT_W = ADDR_W + 1;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam dump_state_t END_STATE = ST_CSUM;
`else
  localparam dump_state_t END_STATE = ST_DONE;
`endif

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] buf_a_q, buf_a_d;
  logic [DATA_W-1:0] buf_b_q, buf_b_d;

  // Modular distance between the range ends; +1 gives the word count 1..2^ADDR_W.
  logic [ADDR_W-1:0] span;
  assign span = last_addr - first_addr;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic              csum_clr;
  logic              csum_en;
  logic [DATA_W-1:0] csum_value;

  regfile_dump_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (csum_clr),
    .en_i   (csum_en),
    .data_i (out_data),
    .sum_o  (csum_value)
  );
`endif

  // Next-state and output logic. Every output is a function of registered
  // state only, so out_valid never depends combinationally on out_ready and
  // out_data/out_last stay put while a word is stalled.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    rf_read     = 1'b0;
    rf_read1    = '0;
    rf_read2    = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_clr    = 1'b0;
    csum_en     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d       = first_addr;
          remaining_d = {1'b0, span} + CNT_W'(1);
          state_d     = ST_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_clr    = 1'b1;
`endif
        end
      end

      ST_FETCH: begin
        // Both ports read in the same cycle; on an odd final pair port 2's
        // word lands in buf_b but is never emitted.
        rf_read  = 1'b1;
        rf_read1 = ptr_q;
        rf_read2 = ptr_q + ADDR_W'(1);
        buf_a_d  = rf_value1;
        buf_b_d  = rf_value2;
        state_d  = ST_SEND_A;
      end

      ST_SEND_A: begin
        out_valid = 1'b1;
        out_data  = buf_a_q;
`ifndef REGFILE_DUMP_CHECKSUM_EN
        out_last  = (remaining_q == CNT_W'(1));
`endif
        if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_en = 1'b1;
`endif
          state_d = (remaining_q == CNT_W'(1)) ? END_STATE : ST_SEND_B;
        end
      end

      ST_SEND_B: begin
        out_valid = 1'b1;
        out_data  = buf_b_q;
`ifndef REGFILE_DUMP_CHECKSUM_EN
        out_last  = (remaining_q == CNT_W'(2));
`endif
        if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_en     = 1'b1;
`endif
          ptr_d       = ptr_q + ADDR_W'(2);
          remaining_d = remaining_q - CNT_W'(2);
          state_d     = (remaining_q == CNT_W'(2)) ? END_STATE : ST_FETCH;
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_value;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
    end
  end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Sequential read-side master for the 16×16-bit register file. On a start pulse it walks a contiguous, wrap-around range of register addresses through the file's two combinational read ports and fetches two registers per access. It then streams the words, one per handshake, on a valid/ready output for debug, scan-out or host readback. It sits beside the register file and owns `read`/`read1`/`read2` while busy.

## Interface
Parameters:
- `DATA_W`, 16, register and stream word width.
- `ADDR_W`, 4, register address width; the range covers 2^ADDR_W registers.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled in IDLE only.
- `first_addr`  in  ADDR_W  first register to emit; sampled with `start`.
- `last_addr`  in  ADDR_W  last register to emit; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through DONE.
- `done`  out  1  one-cycle pulse after the final handshake.
- `rf_read`  out  1  register file read enable; high only in FETCH.
- `rf_read1`  out  ADDR_W  read port 1 address, equal to `ptr`.
- `rf_read2`  out  ADDR_W  read port 2 address, equal to `ptr+1` mod 2^ADDR_W.
- `rf_value1`  in  DATA_W  read port 1 data.
- `rf_value2`  in  DATA_W  read port 2 data.
- `out_data`  out  DATA_W  stream word.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  sink ready.
- `out_last`  out  1  marks the final word of the dump.

## Operation
- States: IDLE, FETCH, SEND_A, SEND_B, CSUM (macro only), DONE.
- IDLE: when `start`=1, latch `ptr`=`first_addr` and `remaining`=((`last_addr`−`first_addr`) mod 2^ADDR_W)+1, then go to FETCH. `remaining` is ADDR_W+1 bits with range 1..16.
- FETCH: drive `rf_read`=1, `rf_read1`=`ptr` and `rf_read2`=`ptr+1`. Capture `rf_value1` into buf_a and `rf_value2` into buf_b at the edge, then go to SEND_A.
- SEND_A: `out_valid`=1 and `out_data`=buf_a. On handshake (`out_valid`&&`out_ready`):
  - if `remaining`=1, go to the end;
  - otherwise go to SEND_B.
- SEND_B: `out_data`=buf_b. On handshake, set `ptr`+=2 and `remaining`−=2:
  - if `remaining` was 2, go to the end;
  - otherwise go to FETCH.
- End: go to CSUM if the macro is defined, else to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Wrap-around:
  - `ptr` and `ptr+1` wrap modulo 2^ADDR_W.
  - `first_addr`=`last_addr` emits exactly one word.
  - `last_addr`=`first_addr`−1 emits all 16 words.
- With an odd count, the final FETCH reads one unused register on port 2; that word is discarded and never emitted.
- `start` is ignored while `busy`. There is no abort; only `reset` terminates a dump.
- Each register is sampled in its pair's FETCH cycle. Writes landing after that cycle are not reflected in the dump.

## Timing
- Reset (asserted asynchronously) forces:
  - state IDLE;
  - `ptr`, `remaining`, buf_a, buf_b and the checksum to 0;
  - outputs `busy`, `done`, `rf_read`, `out_valid` and `out_last` to 0;
  - `out_data`, `rf_read1` and `rf_read2` to 0.
- Reset mid-dump discards all progress. The first word after reset comes only from a new `start`.
- Latency: `start` at edge k gives FETCH in cycle k+1 and the first `out_valid` in cycle k+2.
- Throughput with `out_ready` held high is 2 words per 3 cycles.
- Handshake rules:
  - while `out_valid`&&!`out_ready`, `out_data` and `out_last` hold stable;
  - `out_valid` never drops without a handshake;
  - `out_valid` does not depend combinationally on `out_ready`.
- `out_last`=1 only with the final word of the dump.
- `done` asserts in the cycle after the final handshake. `busy` falls in the cycle after `done`.

## Configuration
- Macro: `REGFILE_DUMP_CHECKSUM_EN`.
- Defined:
  - a DATA_W-bit XOR accumulator, cleared on accepted `start`, XORs in every emitted data word at handshake;
  - CSUM state emits the accumulator with `out_last`=1, followed by DONE.
- Undefined: no accumulator and no CSUM state; `out_last` accompanies the final data word.

## Structure
- Package `regfile_dump_pkg`: the state enum `dump_state_t` and constants `RF_DATA_W`=16, `RF_ADDR_W`=4, `RF_DEPTH`=16.
- One sub-module, `regfile_dump_csum`: the XOR accumulator with clear and enable inputs, instantiated only under the macro.
- Everything else stays in the top FSM.

## Test plan
- Preload register i with 16'hA000+i. Dump `first`=0, `last`=15 with `out_ready`=1 → words A000..A00F in order; `out_last` on A00F, or on checksum 16'h0000 with the macro; `out_valid` 2 cycles after `start`; one `done` pulse.
- `first`=`last`=5 → single word A005 with `out_last`=1 (checksum word A005 with the macro); discarded port-2 data never appears.
- Wrap, `first`=14, `last`=1 → A00E, A00F, A000, A001, then `done`.
- Random `out_ready` toggling on a full dump → `out_data`/`out_last` stable while stalled; no word lost or duplicated.
- Assert `reset` after 3 handshakes → all outputs 0 immediately; a new `start` restarts from `first_addr` with no leftover words.
- Pulse `start` while busy with different addresses → ignored; the current dump completes unchanged.
